// File: rtl/usb_tx_controller.sv
// Packet sequencer for the USB byte transmitter: SYNC, PID, payload from the TX FIFO,
// EOP and a trailing idle J bit, with underrun reporting to the protocol layer.
module usb_tx_controller #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_LEN      = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [6:0] tx_len,
    input  logic       fifo_empty,
    input  logic       Load_Byte,
    output logic [7:0] FSM_byte,
    output logic       select,
    output logic       load_en,
    output logic       Tim_rst,
    output logic       Tim_en,
    output logic       idle,
    output logic       eop,
    output logic       fifo_pop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_SYNC = 3'd1,
        SEND_SYNC = 3'd2,
        SEND_PID  = 3'd3,
        SEND_DATA = 3'd4,
        SEND_EOP  = 3'd5,
        EOP_J     = 3'd6,
        DONE      = 3'd7
    } state_t;

    localparam int              CW        = $clog2(2 * CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   EOP_LAST  = CW'(2 * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   J_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]      MAX_LEN_C = 7'(MAX_LEN);

    state_t        state, state_n;
    logic [3:0]    pid_r, pid_n;
    logic [6:0]    rem, rem_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_n;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            pid_r    <= 4'd0;
            rem      <= 7'd0;
            cnt      <= '0;
            tx_error <= 1'b0;
        end else begin
            state    <= state_n;
            pid_r    <= pid_n;
            rem      <= rem_n;
            cnt      <= cnt_n;
            tx_error <= err_n;
        end
    end

    // Next state; fifo_pop is the only Mealy output, tied to the Load_Byte cycle.
    always_comb begin
        state_n  = state;
        pid_n    = pid_r;
        rem_n    = rem;
        cnt_n    = cnt;
        err_n    = tx_error;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_start) begin
                    pid_n   = tx_pid;
                    rem_n   = (tx_len > MAX_LEN_C) ? MAX_LEN_C : tx_len;
                    err_n   = 1'b0;
                    state_n = LOAD_SYNC;
                end
            end
            LOAD_SYNC: state_n = SEND_SYNC;
            SEND_SYNC: begin
                if (Load_Byte) state_n = SEND_PID;
            end
            SEND_PID, SEND_DATA: begin
                if (Load_Byte) begin
                    if (rem == 7'd0) begin
                        state_n = SEND_EOP;
                        cnt_n   = '0;
                    end else if (fifo_empty) begin
                        // Underrun truncates the packet rather than stalling the line.
                        err_n   = 1'b1;
                        state_n = SEND_EOP;
                        cnt_n   = '0;
                    end else begin
                        fifo_pop = 1'b1;
                        rem_n    = rem - 7'd1;
                        state_n  = SEND_DATA;
                    end
                end
            end
            SEND_EOP: begin
                if (cnt == EOP_LAST) begin
                    cnt_n   = '0;
                    state_n = EOP_J;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EOP_J: begin
                if (cnt == J_LAST) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        FSM_byte = 8'h00;
        select   = 1'b0;
        load_en  = 1'b0;
        Tim_rst  = 1'b0;
        Tim_en   = 1'b0;
        idle     = 1'b0;
        eop      = 1'b0;
        tx_busy  = (state != IDLE);
        tx_done  = 1'b0;
        case (state)
            IDLE: begin
                idle    = 1'b1;
                Tim_rst = 1'b1;
            end
            LOAD_SYNC: begin
                load_en  = 1'b1;
                select   = 1'b1;
                FSM_byte = 8'h80;
                Tim_rst  = 1'b1;
            end
            SEND_SYNC: begin
                Tim_en   = 1'b1;
                select   = 1'b1;
                FSM_byte = {~pid_r, pid_r};
            end
            SEND_PID: begin
                Tim_en   = 1'b1;
                select   = (rem == 7'd0);
                FSM_byte = {~pid_r, pid_r};
            end
            SEND_DATA: begin
                Tim_en   = 1'b1;
                FSM_byte = {~pid_r, pid_r};
            end
            SEND_EOP: eop = 1'b1;
            EOP_J:    idle = 1'b1;
            DONE: begin
                tx_done = 1'b1;
                idle    = 1'b1;
                Tim_rst = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule
